jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1 TAP controller. Replaces the fixed bypass-only TAP in Top.

---
 rtl/jtag_tap_param.sv | 221 ++++++++++++++++++++++
 tb/tb_jtag_tap_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_param.sv
// jtag_tap_param
//   Parametrised IEEE 1149.1 TAP controller. It sits between the chip JTAG pins
//   and the core/pad boundary. It provides a configurable-width instruction
//   register, a 32-bit IDCODE register, a BSR_LEN-cell boundary-scan register
//   (SAMPLE/PRELOAD and EXTEST), a 1-bit BYPASS register, and a pass-through
//   to the core internal scan chain.
//
// Ports
//   TCK        in   1         test clock, the only clock
//   TRST_N     in   1         asynchronous reset, active-low
//   TMS        in   1         mode select, sampled on the TCK rising edge
//   TDI        in   1         serial data in, sampled on the TCK rising edge
//   TDO        out  1         serial data out, updated on the TCK falling edge
//   TDO_EN     out  1         high while in Shift-IR/Shift-DR (same timing as TDO)
//   func_in    in   BSR_LEN   functional core-to-pad values
//   pin_out    out  BSR_LEN   values driven to the pads
//   scan_en    out  1         internal chain shift enable
//   scan_si    out  1         internal chain serial in (copy of TDI)
//   scan_so    in   1         internal chain serial out
//   tap_state  out  4         current TAP state (debug)
//   ir_q       out  IR_WIDTH  current instruction (debug)

module jtag_tap_param #(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter int unsigned         BSR_LEN    = 8,
  parameter logic [31:0]         IDCODE_VAL = 32'h1876_5001,
  parameter logic [IR_WIDTH-1:0] OPC_EXTEST = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] OPC_SAMPLE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OPC_SCAN   = IR_WIDTH'(3)
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [BSR_LEN-1:0]  func_in,
  output logic [BSR_LEN-1:0]  pin_out,
  output logic                scan_en,
  output logic                scan_si,
  input  logic                scan_so,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_q
);

  // The state codes are the values the IEEE 1149.1 documents conventionally
  // use. This lets a debugger read tap_state directly.
  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BSR,
    DR_SCAN
  } dr_sel_e;

  // The IR capture pattern ends in 2'b01, as the standard requires.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IR_WIDTH-1:0] IR_ALL_ONES = '1;

  tap_state_e         state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic               bypass_q;
  logic [31:0]        id_sr_q;
  logic [BSR_LEN-1:0] bsr_sr_q;
  logic [BSR_LEN-1:0] bsr_upd_q;
  logic [BSR_LEN-1:0] bsr_shift_d;
  dr_sel_e            dr_sel;
  logic               dr_lsb;

  // The next state follows the 16-state TAP graph. It is driven only by TMS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:    state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:    state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // The all-ones opcode and any opcode not listed select BYPASS.
  // The all-ones test comes first so that it wins over an overlapping opcode.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == IR_ALL_ONES) begin
      dr_sel = DR_BYPASS;
    end else if ((ir_q == OPC_EXTEST) || (ir_q == OPC_SAMPLE)) begin
      dr_sel = DR_BSR;
    end else if (ir_q == OPC_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir_q == OPC_SCAN) begin
      dr_sel = DR_SCAN;
    end
  end

  // The BSR shifts LSB first. TDI enters at the top cell.
  // The expression is written with shifts so that BSR_LEN == 1 stays legal.
  always_comb begin
    bsr_shift_d = (bsr_sr_q >> 1) | (BSR_LEN'(TDI) << (BSR_LEN - 1));
  end

  // This selects the bit that is presented on TDO for the active data register.
  always_comb begin
    dr_lsb = bypass_q;
    unique case (dr_sel)
      DR_IDCODE: dr_lsb = id_sr_q[0];
      DR_BSR:    dr_lsb = bsr_sr_q[0];
      DR_SCAN:   dr_lsb = scan_so;
      default:   dr_lsb = bypass_q;
    endcase
  end

  // Rising-edge block: the state register, IR, and all data registers.
  // Capture, shift and update happen on the edge taken while in the
  // corresponding state. The Pause and Exit states simply hold.
  // ir_q is forced to IDCODE whenever the next state is TLR, so the value is
  // already correct on the edge that arrives in TLR.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q   <= ST_TLR;
      ir_q      <= OPC_IDCODE;
      ir_sr_q   <= '0;
      bypass_q  <= 1'b0;
      id_sr_q   <= '0;
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_d == ST_TLR) begin
        ir_q <= OPC_IDCODE;
      end else if (state_q == ST_UPD_IR) begin
        ir_q <= ir_sr_q;
      end

      unique case (state_q)
        ST_CAP_IR: ir_sr_q <= IR_CAPTURE;
        ST_SH_IR:  ir_sr_q <= {TDI, ir_sr_q[IR_WIDTH-1:1]};
        ST_CAP_DR: begin
          unique case (dr_sel)
            DR_BYPASS: bypass_q <= 1'b0;
            DR_IDCODE: id_sr_q  <= IDCODE_VAL;
            DR_BSR:    bsr_sr_q <= func_in;
            default:   ;
          endcase
        end
        ST_SH_DR: begin
          unique case (dr_sel)
            DR_BYPASS: bypass_q <= TDI;
            DR_IDCODE: id_sr_q  <= {TDI, id_sr_q[31:1]};
            DR_BSR:    bsr_sr_q <= bsr_shift_d;
            default:   ;
          endcase
        end
        ST_UPD_DR: begin
          if (dr_sel == DR_BSR) begin
            bsr_upd_q <= bsr_sr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Falling-edge block: TDO and TDO_EN are retimed half a cycle after the state
  // change. Outside the shift states, TDO keeps its last value.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else if (state_q == ST_SH_IR) begin
      TDO    <= ir_sr_q[0];
      TDO_EN <= 1'b1;
    end else if (state_q == ST_SH_DR) begin
      TDO    <= dr_lsb;
      TDO_EN <= 1'b1;
    end else begin
      TDO_EN <= 1'b0;
    end
  end

  // The core chain shifts only while its instruction is active and the TAP is
  // in Shift-DR.
  assign scan_en   = (state_q == ST_SH_DR) && (dr_sel == DR_SCAN);
  assign scan_si   = TDI;
  assign pin_out   = (ir_q == OPC_EXTEST) ? bsr_upd_q : func_in;
  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb_jtag_tap_param
//   Self-checking bench for jtag_tap_param with the default parameters.
//   A table of TMS vectors walks the TAP graph. Hand-written sequences cover
//   IDCODE, BYPASS, IR capture, SAMPLE/PRELOAD/EXTEST, SCAN, and both reset
//   paths. Expected TDO bits go into a queue when stimulus is driven. They are
//   popped and compared while TDO_EN is high.

module tb_jtag_tap_param;

  localparam logic [31:0] IDC = 32'h1876_5001;

  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2, S_PAUSEDR = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR = 4'hA, S_PAUSEIR = 4'hB;
  localparam logic [3:0] S_RTI = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR = 4'hF;
  localparam logic [3:0] OID = 4'h2, OEX = 4'h0;

  logic       TCK = 1'b0;
  logic       TRST_N, TMS, TDI, scan_so;
  logic       TDO, TDO_EN, scan_en, scan_si;
  logic [7:0] func_in, pin_out;
  logic [3:0] tap_state, ir_q;

  int   checks = 0;
  int   errors = 0;
  logic expQ[$];

  typedef struct {
    logic       tms;
    logic [3:0] st;
    logic [3:0] ir;
    logic       en;
  } walk_t;
  walk_t walk [29];

  jtag_tap_param #(
    .IR_WIDTH(4),
    .BSR_LEN(8),
    .IDCODE_VAL(IDC)
  ) dut (
    .TCK(TCK),
    .TRST_N(TRST_N),
    .TMS(TMS),
    .TDI(TDI),
    .TDO(TDO),
    .TDO_EN(TDO_EN),
    .func_in(func_in),
    .pin_out(pin_out),
    .scan_en(scan_en),
    .scan_si(scan_si),
    .scan_so(scan_so),
    .tap_state(tap_state),
    .ir_q(ir_q)
  );

  // The free-running test clock has a 10-unit period.
  always #5 TCK = ~TCK;

  // Watchdog so that the run always ends, even if the clock or a task stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One TCK cycle. It is called just after a falling edge and returns just after
  // the next falling edge, so both state and TDO are settled.
  task automatic applyStimulus(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic stepExpect(input logic tms, input logic tdi, input logic [3:0] st);
    applyStimulus(tms, tdi);
    checkOutput("tap_state", 32'(tap_state), 32'(st));
  endtask

  task automatic pushBits(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(d[i]);
  endtask

  task automatic popCheck(input string name);
    logic e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: TDO=%0b but no expected bit was queued", name, TDO);
    end else begin
      e = expQ.pop_front();
      checkOutput(name, 32'(TDO), 32'(e));
      checkOutput({name, "_en"}, 32'(TDO_EN), 32'd1);
    end
  endtask

  // Full IR or DR scan from RTI back to RTI. It shifts n bits from din, LSB
  // first, and checks n TDO bits against the scoreboard.
  task automatic scanReg(input logic isIr, input int n, input logic [63:0] din);
    string tag;
    tag = isIr ? "tdo_ir" : "tdo_dr";
    applyStimulus(1'b1, 1'b0);
    if (isIr) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("shift_state", 32'(tap_state), isIr ? 32'(S_SHIR) : 32'(S_SHDR));
    popCheck(tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus((i == n - 1), din[i]);
      if (i < n - 1) popCheck(tag);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("back_to_rti", 32'(tap_state), 32'(S_RTI));
  endtask

  task automatic loadIr(input logic [3:0] v);
    pushBits(64'h1, 4);
    scanReg(1'b1, 4, 64'(v));
    checkOutput("ir_q", 32'(ir_q), 32'(v));
  endtask

  task automatic doReset();
    TRST_N = 1'b0;
    TMS = 1'b1;
    TDI = 1'b0;
    @(negedge TCK);
    #1;
    checkOutput("rst_state", 32'(tap_state), 32'(S_TLR));
    checkOutput("rst_ir", 32'(ir_q), 32'(OID));
    checkOutput("rst_tdo", 32'(TDO), 32'd0);
    checkOutput("rst_tdo_en", 32'(TDO_EN), 32'd0);
    checkOutput("rst_scan_en", 32'(scan_en), 32'd0);
    checkOutput("rst_pin_out", 32'(pin_out), 32'(func_in));
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
  endtask

  initial begin
    logic [4:0] tdiPat;
    logic [4:0] soPat;

    walk[0]  = '{1'b0, S_RTI,     OID, 1'b0};
    walk[1]  = '{1'b1, S_SELDR,   OID, 1'b0};
    walk[2]  = '{1'b0, S_CAPDR,   OID, 1'b0};
    walk[3]  = '{1'b0, S_SHDR,    OID, 1'b1};
    walk[4]  = '{1'b1, S_EX1DR,   OID, 1'b0};
    walk[5]  = '{1'b0, S_PAUSEDR, OID, 1'b0};
    walk[6]  = '{1'b1, S_EX2DR,   OID, 1'b0};
    walk[7]  = '{1'b0, S_SHDR,    OID, 1'b1};
    walk[8]  = '{1'b1, S_EX1DR,   OID, 1'b0};
    walk[9]  = '{1'b1, S_UPDDR,   OID, 1'b0};
    walk[10] = '{1'b1, S_SELDR,   OID, 1'b0};
    walk[11] = '{1'b1, S_SELIR,   OID, 1'b0};
    walk[12] = '{1'b0, S_CAPIR,   OID, 1'b0};
    walk[13] = '{1'b1, S_EX1IR,   OID, 1'b0};
    walk[14] = '{1'b0, S_PAUSEIR, OID, 1'b0};
    walk[15] = '{1'b1, S_EX2IR,   OID, 1'b0};
    walk[16] = '{1'b0, S_SHIR,    OID, 1'b1};
    walk[17] = '{1'b1, S_EX1IR,   OID, 1'b0};
    walk[18] = '{1'b1, S_UPDIR,   OID, 1'b0};
    walk[19] = '{1'b0, S_RTI,     OEX, 1'b0};
    walk[20] = '{1'b1, S_SELDR,   OEX, 1'b0};
    walk[21] = '{1'b0, S_CAPDR,   OEX, 1'b0};
    walk[22] = '{1'b1, S_EX1DR,   OEX, 1'b0};
    walk[23] = '{1'b1, S_UPDDR,   OEX, 1'b0};
    walk[24] = '{1'b0, S_RTI,     OEX, 1'b0};
    walk[25] = '{1'b1, S_SELDR,   OEX, 1'b0};
    walk[26] = '{1'b1, S_SELIR,   OEX, 1'b0};
    walk[27] = '{1'b1, S_TLR,     OID, 1'b0};
    walk[28] = '{1'b1, S_TLR,     OID, 1'b0};

    TRST_N  = 1'b0;
    TMS     = 1'b1;
    TDI     = 1'b0;
    scan_so = 1'b0;
    func_in = 8'h96;
    doReset();

    // FSM walk through all 16 states. The IR scan at walk[17] shifts a 0 into
    // the captured 4'b0001, so ir_q becomes EXTEST.
    for (int i = 0; i < 29; i++) begin
      applyStimulus(walk[i].tms, 1'b0);
      checkOutput($sformatf("walk%0d_state", i), 32'(tap_state), 32'(walk[i].st));
      checkOutput($sformatf("walk%0d_ir", i), 32'(ir_q), 32'(walk[i].ir));
      checkOutput($sformatf("walk%0d_tdo_en", i), 32'(TDO_EN), 32'(walk[i].en));
    end

    // IDCODE after reset, 32 bits, LSB first.
    doReset();
    stepExpect(1'b0, 1'b0, S_RTI);
    pushBits(64'(IDC), 32);
    scanReg(1'b0, 32, 64'h0);

    // BYPASS via all-ones and via an unlisted opcode: a single-cycle delay.
    loadIr(4'hF);
    pushBits(64'h12, 5);
    scanReg(1'b0, 5, 64'h19);
    loadIr(4'h9);
    pushBits(64'h12, 5);
    scanReg(1'b0, 5, 64'h19);

    // Five TMS=1 edges from Shift-DR reach TLR and restore IDCODE.
    stepExpect(1'b1, 1'b0, S_SELDR);
    stepExpect(1'b0, 1'b0, S_CAPDR);
    stepExpect(1'b0, 1'b0, S_SHDR);
    stepExpect(1'b1, 1'b0, S_EX1DR);
    stepExpect(1'b1, 1'b0, S_UPDDR);
    stepExpect(1'b1, 1'b0, S_SELDR);
    stepExpect(1'b1, 1'b0, S_SELIR);
    stepExpect(1'b1, 1'b0, S_TLR);
    checkOutput("tlr_ir_from_shdr", 32'(ir_q), 32'(OID));

    // Same from Pause-IR. Update-IR loads 4'hC on the way before TLR forces IDCODE.
    stepExpect(1'b0, 1'b0, S_RTI);
    stepExpect(1'b1, 1'b0, S_SELDR);
    stepExpect(1'b1, 1'b0, S_SELIR);
    stepExpect(1'b0, 1'b0, S_CAPIR);
    stepExpect(1'b0, 1'b0, S_SHIR);
    stepExpect(1'b0, 1'b1, S_SHIR);
    stepExpect(1'b1, 1'b1, S_EX1IR);
    stepExpect(1'b0, 1'b0, S_PAUSEIR);
    stepExpect(1'b1, 1'b0, S_EX2IR);
    stepExpect(1'b1, 1'b0, S_UPDIR);
    stepExpect(1'b1, 1'b0, S_SELDR);
    checkOutput("ir_after_upd_ir", 32'(ir_q), 32'hC);
    stepExpect(1'b1, 1'b0, S_SELIR);
    stepExpect(1'b1, 1'b0, S_TLR);
    checkOutput("tlr_ir_from_pause_ir", 32'(ir_q), 32'(OID));
    stepExpect(1'b0, 1'b0, S_RTI);

    // SAMPLE captures func_in while 8'h3C is preloaded. EXTEST then drives it.
    loadIr(4'h1);
    func_in = 8'hA5;
    pushBits(64'hA5, 8);
    scanReg(1'b0, 8, 64'h3C);
    checkOutput("sample_pin_out", 32'(pin_out), 32'hA5);
    loadIr(4'h0);
    checkOutput("extest_pin_out", 32'(pin_out), 32'h3C);
    func_in = 8'h5A;
    #1;
    checkOutput("extest_ignores_func", 32'(pin_out), 32'h3C);
    pushBits(64'h5A, 8);
    scanReg(1'b0, 8, 64'hC3);
    checkOutput("extest_update", 32'(pin_out), 32'hC3);
    loadIr(4'h1);
    checkOutput("back_to_sample", 32'(pin_out), 32'h5A);

    // SCAN pass-through, then an asynchronous reset in the middle of the shift.
    loadIr(4'h3);
    func_in = 8'h77;
    tdiPat  = 5'b10110;
    soPat   = 5'b11010;
    stepExpect(1'b1, 1'b0, S_SELDR);
    checkOutput("scan_en_seldr", 32'(scan_en), 32'd0);
    stepExpect(1'b0, 1'b0, S_CAPDR);
    checkOutput("scan_en_capdr", 32'(scan_en), 32'd0);
    scan_so = soPat[0];
    expQ.push_back(soPat[0]);
    stepExpect(1'b0, tdiPat[0], S_SHDR);
    checkOutput("scan_en_shdr", 32'(scan_en), 32'd1);
    checkOutput("scan_si0", 32'(scan_si), 32'(tdiPat[0]));
    popCheck("scan_tdo");
    for (int i = 1; i < 5; i++) begin
      scan_so = soPat[i];
      expQ.push_back(soPat[i]);
      stepExpect(1'b0, tdiPat[i], S_SHDR);
      checkOutput($sformatf("scan_en%0d", i), 32'(scan_en), 32'd1);
      checkOutput($sformatf("scan_si%0d", i), 32'(scan_si), 32'(tdiPat[i]));
      popCheck("scan_tdo");
    end
    TRST_N = 1'b0;
    #1;
    checkOutput("midrst_state", 32'(tap_state), 32'(S_TLR));
    checkOutput("midrst_tdo_en", 32'(TDO_EN), 32'd0);
    checkOutput("midrst_tdo", 32'(TDO), 32'd0);
    checkOutput("midrst_pin_out", 32'(pin_out), 32'h77);
    checkOutput("midrst_scan_en", 32'(scan_en), 32'd0);
    checkOutput("midrst_ir", 32'(ir_q), 32'(OID));
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
    stepExpect(1'b0, 1'b0, S_RTI);
    loadIr(4'h0);
    checkOutput("latch_cleared", 32'(pin_out), 32'h00);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
